compliment_code: RTL and testbench
==================================

Name: compliment_code

Overview:
- Dual-lane sign/complement code converter. Two independent N-bit operands (A, B) are converted each cycle, in the same direction for both lanes.
- Direction is selected by mode:
  - sign-magnitude to two's complement, or
  - two's complement to sign-magnitude.
- Results are registered on clk1.
- Sits in arithmetic datapaths between sign-magnitude sources (ADC/sensor formats) and two's-complement ALUs.

Parameters:
- bitNumber, 8, operand width N including sign bit; legal range 2..64. The block is undefined for values below 2, and simulation must flag them with a $fatal/$error at elaboration.

Ports:
- clk1  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  A/B/mode are sampled when high.
- mode  input  1  0 = sign-magnitude to two's complement (SM2TC); 1 = two's complement to sign-magnitude (TC2SM).
- A  input  bitNumber  operand lane A.
- B  input  bitNumber  operand lane B.
- Aout  output  bitNumber  converted lane A, registered.
- Bout  output  bitNumber  converted lane B, registered.
- out_valid  output  1  Aout/Bout hold a new result.
- A_ovf  output  1  lane A result not representable (TC2SM only).
- B_ovf  output  1  lane B result not representable (TC2SM only).

Behaviour:
- Clock and reset:
  - Single clock, clk1.
  - When rst_n = 0 at a rising edge: Aout = 0, Bout = 0, out_valid = 0, A_ovf = 0, B_ovf = 0.
  - Reset has priority over in_valid.
  - A transfer sampled in the same cycle as reset is discarded.
- Latency and handshake:
  - Latency is 1 cycle: a transfer with in_valid = 1 at edge k appears with out_valid = 1 after edge k.
  - out_valid is a one-cycle pulse per accepted transfer; back-to-back transfers give continuous out_valid.
  - There is no backpressure.
  - When in_valid = 0, Aout/Bout/ovf hold their last values and out_valid = 0.
- Per lane, with x the input, s = x[N-1], m = x[N-2:0]:
  - SM2TC:
    - s = 0 gives y = x.
    - s = 1 gives y = -{0,m}, taken modulo 2^N.
    - Negative zero (s = 1, m = 0) gives y = 0.
    - ovf = 0 always.
  - TC2SM:
    - s = 0 gives y = x.
    - s = 1 and x != 100...0 gives y = {1, (-x)[N-2:0]}.
    - x = 100...0 (most negative) is not representable. Output saturates to y = all ones (sign 1, maximum magnitude) and ovf = 1.
- Lanes A and B are fully independent except for the shared mode and in_valid.
- All arithmetic is unsigned N-bit, with wrap-around discarded.
- No internal state beyond the output registers (plus the optional stage).

Optional Feature:
- Macro: COMPLIMENT_CODE_PIPE_EN.
- When defined:
  - A second register stage is added after the conversion registers, giving latency 2 cycles.
  - out_valid and the ovf flags are delayed identically.
  - Reset clears both stages.
  - Throughput remains one transfer per cycle.
- When undefined: latency is 1 cycle, as specified above.

Decomposition:
- Package compliment_code_pkg holds:
  - MODE_SM2TC = 1'b0 and MODE_TC2SM = 1'b1 constants.
  - The latency localparam (1 or 2, depending on the macro).
- Sub-module compliment_code_lane: purely combinational converter (x, mode) -> (y, ovf), parameterised by bitNumber.
- The top instantiates compliment_code_lane twice and owns all registers, valid logic, and the optional pipeline stage.

Test Plan:
All scenarios use bitNumber = 8.
1. Reset:
   - Stimulus: hold rst_n = 0 for 2 cycles with in_valid = 1, A = 8'h85.
   - Required: Aout = Bout = 0, out_valid = 0, ovf = 0 throughout. The first output appears only after a transfer sampled with rst_n = 1.
2. SM2TC:
   - Stimulus: mode = 0, A = 8'h85, B = 8'h05.
   - Required: next cycle Aout = 8'hFB, Bout = 8'h05, out_valid = 1, A_ovf = B_ovf = 0.
3. SM2TC negative zero and extremes:
   - Stimulus: A = 8'h80, B = 8'hFF.
   - Required: Aout = 8'h00, Bout = 8'h81.
4. TC2SM:
   - Stimulus: mode = 1, A = 8'hFB, B = 8'h7F.
   - Required: Aout = 8'h85, Bout = 8'h7F.
   - Then A = 8'h80: Aout = 8'hFF, A_ovf = 1, B_ovf = 0.
5. Streaming and hold:
   - Stimulus: 4 back-to-back transfers with alternating mode, then in_valid = 0.
   - Required: out_valid is high for exactly 4 consecutive cycles, then low; outputs hold the last result.
6. Reset mid-stream and optional pipeline:
   - Stimulus: assert rst_n = 0 between transfers.
   - Required: in-flight result is dropped, all outputs are 0, and no spurious out_valid occurs.
   - With COMPLIMENT_CODE_PIPE_EN defined, scenario 2 results appear 2 cycles after sampling.

Source files
------------

// File: rtl/compliment_code_pkg.sv
// compliment_code_pkg
//   Shared constants for the dual-lane sign/complement code converter.
//   MODE_SM2TC / MODE_TC2SM : encodings of the mode input.
//   LATENCY                 : cycles from an accepted transfer to out_valid.
// Optional build macro: COMPLIMENT_CODE_PIPE_EN adds a second output stage.
package compliment_code_pkg;

    localparam logic MODE_SM2TC = 1'b0;
    localparam logic MODE_TC2SM = 1'b1;

`ifdef COMPLIMENT_CODE_PIPE_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/compliment_code_if.sv
// compliment_code_if
//   Bundles the converter's transfer signals.
//   in_valid, mode, A, B     : request side (driven by master).
//   Aout, Bout, out_valid,
//   A_ovf, B_ovf             : result side (driven by slave, the converter).
interface compliment_code_if #(
    parameter int bitNumber = 8
);
    logic                 in_valid;
    logic                 mode;
    logic [bitNumber-1:0] A;
    logic [bitNumber-1:0] B;
    logic [bitNumber-1:0] Aout;
    logic [bitNumber-1:0] Bout;
    logic                 out_valid;
    logic                 A_ovf;
    logic                 B_ovf;

    modport master (
        output in_valid, mode, A, B,
        input  Aout, Bout, out_valid, A_ovf, B_ovf
    );

    modport slave (
        input  in_valid, mode, A, B,
        output Aout, Bout, out_valid, A_ovf, B_ovf
    );
endinterface

// File: rtl/compliment_code_lane.sv
// compliment_code_lane
//   Purely combinational converter for one operand lane.
//   x_i    : operand (bitNumber bits, MSB is the sign).
//   mode_i : MODE_SM2TC or MODE_TC2SM.
//   y_o    : converted value.
//   ovf_o  : set when a TC2SM input (most negative) cannot be represented.
module compliment_code_lane
    import compliment_code_pkg::*;
#(
    parameter int bitNumber = 8
) (
    input  logic [bitNumber-1:0] x_i,
    input  logic                 mode_i,
    output logic [bitNumber-1:0] y_o,
    output logic                 ovf_o
);

    localparam int N = bitNumber;
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    // Negating {0,m} modulo 2^N also folds negative zero onto zero.
    function automatic logic [N-1:0] sm2tc(input logic [N-1:0] x);
        if (!x[N-1]) return x;
        return (~{1'b0, x[N-2:0]}) + ONE;
    endfunction

    // Returns {ovf, y}; the most negative code saturates to all ones.
    function automatic logic [N:0] tc2sm(input logic [N-1:0] x);
        logic [N-1:0] neg;
        neg = (~x) + ONE;
        if (!x[N-1])       return {1'b0, x};
        if (x == MOST_NEG) return {1'b1, {N{1'b1}}};
        return {1'b0, 1'b1, neg[N-2:0]};
    endfunction

    logic [N:0] tc_res;

    always_comb begin
        tc_res = tc2sm(x_i);
        y_o    = sm2tc(x_i);
        ovf_o  = 1'b0;
        if (mode_i == MODE_TC2SM) begin
            y_o   = tc_res[N-1:0];
            ovf_o = tc_res[N];
        end
    end

endmodule

// File: rtl/compliment_code.sv
// compliment_code
//   Dual-lane sign-magnitude <-> two's-complement converter with registered
//   outputs. Both lanes share mode and in_valid.
//   clk1  : clock, rising edge.
//   rst_n : synchronous active-low reset, clears all output state.
//   bus   : compliment_code_if.slave (in_valid, mode, A, B in;
//           Aout, Bout, out_valid, A_ovf, B_ovf out).
// Optional build macro: COMPLIMENT_CODE_PIPE_EN adds a second register stage
// (latency 2 instead of 1, full throughput kept).
module compliment_code
    import compliment_code_pkg::*;
#(
    parameter int bitNumber = 8
) (
    input  logic             clk1,
    input  logic             rst_n,
    compliment_code_if.slave bus
);

    if (bitNumber < 2 || bitNumber > 64) begin : g_bad_width
        $fatal(1, "compliment_code: bitNumber=%0d outside legal range 2..64", bitNumber);
    end

    logic [bitNumber-1:0] a_d, b_d;
    logic                 a_ovf_d, b_ovf_d;

    compliment_code_lane #(.bitNumber(bitNumber)) u_lane_a (
        .x_i   (bus.A),
        .mode_i(bus.mode),
        .y_o   (a_d),
        .ovf_o (a_ovf_d)
    );

    compliment_code_lane #(.bitNumber(bitNumber)) u_lane_b (
        .x_i   (bus.B),
        .mode_i(bus.mode),
        .y_o   (b_d),
        .ovf_o (b_ovf_d)
    );

    // ---- stage p1: conversion registers ----
    logic [bitNumber-1:0] a_p1_q, b_p1_q;
    logic                 a_ovf_p1_q, b_ovf_p1_q, vld_p1_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            a_p1_q     <= '0;
            b_p1_q     <= '0;
            a_ovf_p1_q <= 1'b0;
            b_ovf_p1_q <= 1'b0;
            vld_p1_q   <= 1'b0;
        end else begin
            vld_p1_q <= bus.in_valid;
            if (bus.in_valid) begin
                a_p1_q     <= a_d;
                b_p1_q     <= b_d;
                a_ovf_p1_q <= a_ovf_d;
                b_ovf_p1_q <= b_ovf_d;
            end
        end
    end

`ifdef COMPLIMENT_CODE_PIPE_EN
    // ---- stage p2: optional output registers ----
    logic [bitNumber-1:0] a_p2_q, b_p2_q;
    logic                 a_ovf_p2_q, b_ovf_p2_q, vld_p2_q;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            a_p2_q     <= '0;
            b_p2_q     <= '0;
            a_ovf_p2_q <= 1'b0;
            b_ovf_p2_q <= 1'b0;
            vld_p2_q   <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                a_p2_q     <= a_p1_q;
                b_p2_q     <= b_p1_q;
                a_ovf_p2_q <= a_ovf_p1_q;
                b_ovf_p2_q <= b_ovf_p1_q;
            end
        end
    end

    assign bus.Aout      = a_p2_q;
    assign bus.Bout      = b_p2_q;
    assign bus.A_ovf     = a_ovf_p2_q;
    assign bus.B_ovf     = b_ovf_p2_q;
    assign bus.out_valid = vld_p2_q;
`else
    assign bus.Aout      = a_p1_q;
    assign bus.Bout      = b_p1_q;
    assign bus.A_ovf     = a_ovf_p1_q;
    assign bus.B_ovf     = b_ovf_p1_q;
    assign bus.out_valid = vld_p1_q;
`endif

endmodule

// File: tb/tb_compliment_code.sv
// tb_compliment_code
//   Directed bench for compliment_code at bitNumber = 8. Handles either
//   build latency through compliment_code_pkg::LATENCY.
module tb_compliment_code;
    import compliment_code_pkg::*;

    logic clk1 = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk1 = ~clk1;

    compliment_code_if #(.bitNumber(8)) bus ();

    compliment_code #(.bitNumber(8)) dut (
        .clk1 (clk1),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Present one transfer, then wait until its result should be visible,
    // confirming out_valid stays low during any extra pipeline cycles.
    task automatic xfer(input logic md, input logic [7:0] a, input logic [7:0] b);
        bus.mode     = md;
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 1; i < LATENCY; i++) begin
            chk("lat_gap_vld", {63'd0, bus.out_valid}, 64'd0);
            tick();
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic eva, input logic evb, input logic ev);
        chk({tag, "_Aout"},  {56'd0, bus.Aout},      {56'd0, ea});
        chk({tag, "_Bout"},  {56'd0, bus.Bout},      {56'd0, eb});
        chk({tag, "_Aovf"},  {63'd0, bus.A_ovf},     {63'd0, eva});
        chk({tag, "_Bovf"},  {63'd0, bus.B_ovf},     {63'd0, evb});
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, {63'd0, ev});
    endtask

    // Streaming vectors, alternating mode, with hand-computed results.
    logic       s_md [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    logic [7:0] s_a  [4] = '{8'h85, 8'hFB, 8'hFF, 8'h81};
    logic [7:0] s_b  [4] = '{8'h05, 8'h80, 8'h80, 8'h7F};
    logic [7:0] s_ea [4] = '{8'hFB, 8'h85, 8'h81, 8'hFF};
    logic [7:0] s_eb [4] = '{8'h05, 8'hFF, 8'h00, 8'h7F};
    logic       s_vb [4] = '{1'b0,  1'b1,  1'b0,  1'b0};

    initial begin
        int idx;
        // Reset held with a pending transfer: nothing may emerge.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.mode     = MODE_SM2TC;
        bus.A        = 8'h85;
        bus.B        = 8'h05;
        tick();
        chk_out("rst1", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_out("rst2", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk_out("post_rst_idle", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        // SM2TC basic, negative zero and extreme magnitude.
        xfer(MODE_SM2TC, 8'h85, 8'h05);
        chk_out("sm2tc", 8'hFB, 8'h05, 1'b0, 1'b0, 1'b1);
        xfer(MODE_SM2TC, 8'h80, 8'hFF);
        chk_out("sm2tc_ext", 8'h00, 8'h81, 1'b0, 1'b0, 1'b1);

        // TC2SM basic and most-negative saturation.
        xfer(MODE_TC2SM, 8'hFB, 8'h7F);
        chk_out("tc2sm", 8'h85, 8'h7F, 1'b0, 1'b0, 1'b1);
        xfer(MODE_TC2SM, 8'h80, 8'h7F);
        chk_out("tc2sm_sat", 8'hFF, 8'h7F, 1'b1, 1'b0, 1'b1);
        tick();
        chk_out("hold_after_pulse", 8'hFF, 8'h7F, 1'b1, 1'b0, 1'b0);

        // Four back-to-back transfers, then idle.
        for (int c = 0; c < 9; c++) begin
            if (c < 4) begin
                bus.mode     = s_md[c];
                bus.A        = s_a[c];
                bus.B        = s_b[c];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            idx = c - (LATENCY - 1);
            if (idx >= 0 && idx < 4) begin
                chk_out($sformatf("stream%0d", idx), s_ea[idx], s_eb[idx],
                        1'b0, s_vb[idx], 1'b1);
            end else begin
                chk($sformatf("stream_idle_vld_c%0d", c), {63'd0, bus.out_valid}, 64'd0);
            end
        end
        chk_out("stream_hold", 8'hFF, 8'h7F, 1'b0, 1'b0, 1'b0);

        // Reset between transfers drops the in-flight result.
        bus.mode     = MODE_SM2TC;
        bus.A        = 8'h85;
        bus.B        = 8'h05;
        bus.in_valid = 1'b1;
        tick();
        rst_n        = 1'b0;
        bus.A        = 8'hFB;
        tick();
        chk_out("midrst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out($sformatf("midrst_idle%0d", c), 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Recovery after reset.
        xfer(MODE_SM2TC, 8'h85, 8'h05);
        chk_out("recover", 8'hFB, 8'h05, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
